axi_lite_mem_responder: RTL and testbench

//   AXI4-Lite subordinate (responder) serving single-beat word reads and writes from an internal word memory.

---
 rtl/axi_lite_pkg.sv | 14 +
 rtl/axi_mem_array.sv | 41 ++++
 rtl/axi_lite_mem_responder.sv | 145 ++++++++++++++
 tb/tb_axi_lite_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and responder state type for the AXI4-Lite memory responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRData = 2'd1,
        StWData = 2'd2,
        StWResp = 2'd3
    } t_resp_state;

endpackage

// File: rtl/axi_mem_array.sv
// Single-port word array with per-byte write enables and a registered read port.
// The read register only changes on a read access, so its value holds between reads.
module axi_mem_array #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 256,
    parameter int unsigned AddrW     = $clog2(Depth)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   req,
    input  logic                   we,
    input  logic [DataWidth/8-1:0] be,
    input  logic [AddrW-1:0]       addr,
    input  logic [DataWidth-1:0]   wdata,
    output logic [DataWidth-1:0]   rdata
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (req && we) begin
            for (int unsigned b = 0; b < DataWidth / 8; b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rdata_q <= '0;
        end else if (req && !we) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder serving single-beat word reads/writes from an internal memory.
// Define MEM_RESP_ERR_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module axi_lite_mem_responder
    import axi_lite_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned MEM_DEPTH      = 256
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_arvalid,
    output logic                        o_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_araddr,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic [AXI_DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]                  o_rresp,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    output logic [1:0]                  o_bresp
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    t_resp_state     state_q, state_d;
    logic [IdxW-1:0] aw_idx_q, aw_idx_d;
    logic            aw_err_q, aw_err_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [1:0]      bresp_q, bresp_d;

    logic [IdxW-1:0]           ar_idx, aw_idx, mem_addr;
    logic                      ar_err, aw_err;
    logic                      ar_hs, aw_hs, w_hs;
    logic                      mem_req;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;
    logic                      unused_addr;

    assign ar_idx = i_araddr[IdxW+1:2];
    assign aw_idx = i_awaddr[IdxW+1:2];

`ifdef MEM_RESP_ERR_EN
    assign ar_err = |i_araddr[AXI_ADDR_WIDTH-1:IdxW+2];
    assign aw_err = |i_awaddr[AXI_ADDR_WIDTH-1:IdxW+2];
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // Byte offset is ignored; upper bits only matter when range errors are enabled.
    assign unused_addr = ^{i_araddr[1:0], i_awaddr[1:0],
                           i_araddr[AXI_ADDR_WIDTH-1:IdxW+2], i_awaddr[AXI_ADDR_WIDTH-1:IdxW+2]};

    assign o_awready = (state_q == StIdle);
    assign o_arready = (state_q == StIdle) && !i_awvalid;
    assign o_wready  = (state_q == StWData);
    assign o_rvalid  = (state_q == StRData);
    assign o_bvalid  = (state_q == StWResp);
    assign o_rresp   = rresp_q;
    assign o_bresp   = bresp_q;

    assign aw_hs = (state_q == StIdle) && i_awvalid;
    assign ar_hs = o_arready && i_arvalid;
    assign w_hs  = (state_q == StWData) && i_wvalid;

    // Out-of-range writes never touch the array; reads fetch but the data is masked below.
    assign mem_req  = ar_hs || (w_hs && !aw_err_q);
    assign mem_addr = (state_q == StWData) ? aw_idx_q : ar_idx;
    assign o_rdata  = (rresp_q == RESP_SLVERR) ? '0 : mem_rdata;

    always_comb begin
        state_d  = state_q;
        aw_idx_d = aw_idx_q;
        aw_err_d = aw_err_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;
        unique case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    aw_idx_d = aw_idx;
                    aw_err_d = aw_err;
                    state_d  = StWData;
                end else if (ar_hs) begin
                    rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = StRData;
                end
            end
            StRData: begin
                if (i_rready) begin
                    state_d = StIdle;
                end
            end
            StWData: begin
                if (w_hs) begin
                    bresp_d = aw_err_q ? RESP_SLVERR : RESP_OKAY;
                    state_d = StWResp;
                end
            end
            StWResp: begin
                if (i_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= StIdle;
            aw_idx_q <= '0;
            aw_err_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            bresp_q  <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            aw_idx_q <= aw_idx_d;
            aw_err_q <= aw_err_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
        end
    end

    axi_mem_array #(
        .DataWidth (AXI_DATA_WIDTH),
        .Depth     (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .arst  (arst),
        .req   (mem_req),
        .we    (w_hs),
        .be    (i_wstrb),
        .addr  (mem_addr),
        .wdata (i_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Scoreboard bench for axi_lite_mem_responder: drivers push expected responses from a
// word-array reference model; a negedge monitor pops and compares on each R/B handshake.
module tb_axi_lite_mem_responder;

    localparam int DW    = 32;
    localparam int AW    = 64;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            arst;
    logic            i_arvalid = 1'b0, o_arready;
    logic [AW-1:0]   i_araddr = '0;
    logic            o_rvalid, i_rready = 1'b0;
    logic [DW-1:0]   o_rdata;
    logic [1:0]      o_rresp;
    logic            i_awvalid = 1'b0, o_awready;
    logic [AW-1:0]   i_awaddr = '0;
    logic            i_wvalid = 1'b0, o_wready;
    logic [DW-1:0]   i_wdata = '0;
    logic [DW/8-1:0] i_wstrb = '0;
    logic            o_bvalid, i_bready = 1'b0;
    logic [1:0]      o_bresp;

    always #5 clk = ~clk;

    axi_lite_mem_responder dut (
        .clk       (clk),
        .arst      (arst),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .i_araddr  (i_araddr),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready),
        .o_rdata   (o_rdata),
        .o_rresp   (o_rresp),
        .i_awvalid (i_awvalid),
        .o_awready (o_awready),
        .i_awaddr  (i_awaddr),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .o_bvalid  (o_bvalid),
        .i_bready  (i_bready),
        .o_bresp   (o_bresp)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [33:0] rq [$];
    logic [1:0]  bq [$];

    int r_hs_cnt  = 0;
    int ar_hs_cnt = 0;
    bit          stall = 1'b0;
    logic [33:0] held;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit out_of_range(logic [63:0] a);
`ifdef MEM_RESP_ERR_EN
        return a >= 64'(DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(logic [63:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [1:0] model_write(logic [63:0] a, logic [31:0] d, logic [3:0] s);
        int w;
        if (out_of_range(a)) return 2'b10;
        w = word_of(a);
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(logic [63:0] a);
        if (out_of_range(a)) return {2'b10, 32'h0};
        return {2'b00, ref_mem[word_of(a)]};
    endfunction

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return {$urandom, $urandom};
        return 64'($urandom_range(0, DEPTH - 1)) * 4 + 64'($urandom_range(0, 3));
    endfunction

    // Called just after a rising edge; returns just after the rising edge of the B handshake.
    task automatic do_write(logic [63:0] a, logic [31:0] d, logic [3:0] s, int dly, bit abort);
        int n;
        logic [1:0] e;
        e = model_write(a, d, s);
        if (!abort) bq.push_back(e);
        i_awvalid = 1'b1;
        i_awaddr  = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_awready && n < 50);
        chk("aw_accept", o_awready, 1);
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        i_wvalid  = 1'b1;
        i_wdata   = d;
        i_wstrb   = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_wready && n < 50);
        chk("w_accept", o_wready, 1);
        @(posedge clk); #1;
        i_wvalid = 1'b0;
        if (!abort && dly == 0) i_bready = 1'b1;
        @(negedge clk);
        chk("b_latency", o_bvalid, 1);
        if (abort) begin
            #2 arst = 1'b0;
            #1;
            chk("bvalid_async_clear", o_bvalid, 0);
            chk("awready_after_reset", o_awready, 1);
            @(posedge clk); #1;
            arst = 1'b1;
            return;
        end
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1 i_bready = 1'b1;
        end
        @(posedge clk); #1;
        i_bready = 1'b0;
    endtask

    task automatic do_read(logic [63:0] a, int dly);
        int n;
        rq.push_back(model_read(a));
        i_arvalid = 1'b1;
        i_araddr  = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_arready && n < 50);
        chk("ar_accept", o_arready, 1);
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        if (dly == 0) i_rready = 1'b1;
        @(negedge clk);
        chk("r_latency", o_rvalid, 1);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1 i_rready = 1'b1;
        end
        @(posedge clk); #1;
        i_rready = 1'b0;
    endtask

    // Monitor: compares every R/B handshake against the head of its queue.
    always @(negedge clk) begin
        logic [33:0] er;
        logic [1:0]  eb;
        if (arst) begin
            if (stall) begin
                chk("r_hold_valid", o_rvalid, 1);
                chk("r_hold_data", {o_rresp, o_rdata}, held);
            end
            if (o_rvalid && i_rready) begin
                r_hs_cnt++;
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    er = rq.pop_front();
                    chk("rdata", o_rdata, er[31:0]);
                    chk("rresp", o_rresp, er[33:32]);
                end
            end
            if (o_bvalid && i_bready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    eb = bq.pop_front();
                    chk("bresp", o_bresp, eb);
                end
            end
            if (o_arready && i_arvalid) ar_hs_cnt++;
            stall = o_rvalid && !i_rready;
            held  = {o_rresp, o_rdata};
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        int c0;
        int ops;
        logic [63:0] wa, ra;
        arst = 1'b1;
        #2 arst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rresp", o_rresp, 0);
        chk("rst_bresp", o_bresp, 0);
        chk("rst_awready", o_awready, 1);
        chk("rst_arready", o_arready, 1);
        chk("rst_wready", o_wready, 0);
        @(posedge clk); #1;
        arst = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_write(64'(i * 4), $urandom, 4'hF, 0, 1'b0);

        do_write(64'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        do_read(64'h10, 0);
        do_write(64'h10, 32'h0000CAFE, 4'b0011, 1, 1'b0);
        do_read(64'h10, 0);

        c0 = r_hs_cnt;
        do_read(64'h10, 5);
        chk("stall_one_handshake", 64'(r_hs_cnt - c0), 1);

        c0 = ar_hs_cnt;
        i_arvalid = 1'b1;
        i_araddr  = 64'h20;
        do_write(64'h20, 32'h12345678, 4'hF, 0, 1'b0);
        chk("read_waits_for_write", 64'(ar_hs_cnt - c0), 0);
        do_read(64'h20, 0);

        do_write(64'(DEPTH * 4), 32'hA5A5A5A5, 4'hF, 0, 1'b0);
        do_read(64'h0, 0);

        do_write(64'h44, 32'h0BADF00D, 4'hF, 0, 1'b1);
        do_write(64'h48, 32'h600DCAFE, 4'hC, 2, 1'b0);
        do_read(64'h48, 1);
        do_read(64'h44, 0);

        for (int i = 0; i < 300; i++) begin
            ops = $urandom_range(0, 2);
            wa  = rand_addr();
            ra  = rand_addr();
            if (ops == 0) begin
                do_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0);
            end else if (ops == 1) begin
                do_read(ra, $urandom_range(0, 3));
            end else begin
                i_arvalid = 1'b1;
                i_araddr  = ra;
                do_write(wa, $urandom, 4'($urandom), $urandom_range(0, 2), 1'b0);
                do_read(ra, $urandom_range(0, 2));
            end
        end

        repeat (5) @(posedge clk);
        chk("rq_drained", 64'(rq.size()), 0);
        chk("bq_drained", 64'(bq.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
